// File: rtl/imm_pkg.sv
// Shared opcode constants, format codes and XLEN legality helper for the
// immediate-generation stage.
package imm_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } fmt_e;

  function automatic bit xlen_ok(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational RV immediate decoder: instruction -> {imm, fmt, illegal}.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  logic [2:0] f3;
  logic [5:0] shamt;

  assign f3    = instr_i[14:12];
  assign shamt = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    imm_o     = '0;
    fmt_o     = FMT_R;
    illegal_o = 1'b0;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm_o = sx({instr_i[31:12], 12'b0});
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm_o = sx({{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0});
      end
      OPC_JALR, OPC_LOAD: begin
        fmt_o = FMT_I;
        imm_o = sx({{20{instr_i[31]}}, instr_i[31:20]});
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm_o = sx({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm_o = sx({{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0});
      end
      OPC_OP_IMM: begin
        fmt_o = FMT_I;
        // slli/srli/srai carry an unsigned shift amount, not a signed imm
        if (f3[1:0] == 2'b01) begin
          imm_o     = XLEN'(shamt);
          illegal_o = (XLEN == 32) && instr_i[25];
        end else begin
          imm_o = sx({{20{instr_i[31]}}, instr_i[31:20]});
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          fmt_o = FMT_I;
          imm_o = sx({{20{instr_i[31]}}, instr_i[31:20]});
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_OP: fmt_o = FMT_R;
      OPC_OP_32: illegal_o = (XLEN != 64);
      OPC_SYSTEM: begin
        if (f3[2]) begin
          fmt_o = FMT_Z;
          imm_o = XLEN'(instr_i[19:15]);
        end else begin
          fmt_o = FMT_I;
          imm_o = sx({{20{instr_i[31]}}, instr_i[31:20]});
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decode on input, one-cycle latency, optional
// two-entry skid buffer for full throughput with a registered in_ready.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  localparam int EW = 32 + XLEN + 3 + 1;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_ill)
  );

  logic [EW-1:0] new_e, main_q, main_d, skid_q, skid_d;
  logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic          accept, drain;

  assign new_e    = {in_instr, dec_imm, dec_fmt, dec_ill};
  assign in_ready = SKID ? rdy_q : (!main_vld_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = main_vld_q && out_ready;

  // The skid entry is only ever occupied behind a valid output entry, so the
  // output slot refills from skid first to keep FIFO order.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) skid_d = new_e;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = new_e;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_d     = new_e;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign out_valid = main_vld_q;
  assign {out_instr, out_imm, out_fmt, out_illegal} = main_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (XLEN32/SKID1, XLEN64/SKID1,
// XLEN32/SKID0) share stimulus; each has its own queue-based reference.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  wire [2:0]  irdy, ovld, oill;
  wire [31:0] oinstr [3];
  wire [63:0] oimm   [3];
  wire [2:0]  ofmt   [3];

  int errs = 0, checks = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode from the ISA field definitions using 64-bit arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] ins, input int xl);
    exp_t   e;
    longint s, hi, r;
    s  = longint'($signed(ins));
    hi = s >>> 31;
    e  = '{imm: 64'd0, fmt: 3'd0, ill: 1'b0};
    case (ins[6:0])
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = s & ~64'hFFF; end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = (hi << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
              | (64'(ins[30:21]) << 1);
      end
      7'h67, 7'h03: begin e.fmt = 3'd1; r = s >>> 20; e.imm = r; end
      7'h23: begin
        e.fmt = 3'd2; r = s >>> 25;
        e.imm = (r << 5) | 64'(ins[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = (hi << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
              | (64'(ins[11:8]) << 1);
      end
      7'h13: begin
        e.fmt = 3'd1;
        if (ins[13:12] == 2'b01) begin
          e.imm = (xl == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
          e.ill = (xl == 32) && ins[25];
        end else begin
          r = s >>> 20; e.imm = r;
        end
      end
      7'h1B: if (xl == 64) begin e.fmt = 3'd1; r = s >>> 20; e.imm = r; end
             else e.ill = 1'b1;
      7'h33: e.fmt = 3'd0;
      7'h3B: e.ill = (xl != 64);
      7'h73: if (ins[14]) begin e.fmt = 3'd6; e.imm = 64'(ins[19:15]); end
             else begin e.fmt = 3'd1; r = s >>> 20; e.imm = r; end
      default: e.ill = 1'b1;
    endcase
    if (xl == 32) e.imm = e.imm & 64'hFFFF_FFFF;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int XL = (g == 1) ? 64 : 32;
    localparam bit SK = (g != 2);
    logic [XL-1:0] imm_w;

    imm_gen_stage #(.XLEN(XL), .SKID(SK)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(irdy[g]), .in_instr(in_instr),
      .out_valid(ovld[g]), .out_ready(out_ready), .out_instr(oinstr[g]),
      .out_imm(imm_w), .out_fmt(ofmt[g]), .out_illegal(oill[g])
    );
    assign oimm[g] = 64'(imm_w);

    exp_t        q  [$];
    logic [31:0] qi [$];

    always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        qi.delete();
      end else begin : mdl
        bit    er;
        string t;
        t  = $sformatf("d%0d", g);
        er = SK ? (q.size() < 2) : (q.size() == 0 || out_ready);
        chk({t, ".rdy"}, 64'(irdy[g]), 64'(er));
        chk({t, ".vld"}, 64'(ovld[g]), 64'(q.size() > 0));
        if (q.size() > 0) begin
          chk({t, ".instr"}, 64'(oinstr[g]), 64'(qi[0]));
          chk({t, ".imm"},   oimm[g],        q[0].imm);
          chk({t, ".fmt"},   64'(ofmt[g]),   64'(q[0].fmt));
          chk({t, ".ill"},   64'(oill[g]),   64'(q[0].ill));
        end
        if (flush) begin
          q.delete();
          qi.delete();
        end else begin
          if (q.size() > 0 && out_ready) begin
            void'(q.pop_front());
            void'(qi.pop_front());
          end
          if (in_valid && er) begin
            q.push_back(ref_dec(in_instr, XL));
            qi.push_back(in_instr);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0]  pool [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                               7'h23, 7'h13, 7'h1B, 7'h33, 7'h3B, 7'h73};
    logic [31:0] r;
    logic [6:0]  op;
    r  = $urandom();
    op = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : pool[$urandom_range(0, 11)];
    return {r[31:7], op};
  endfunction

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_instr  = rnd_instr();
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    repeat (2) @(posedge clk);
    #2;
    for (int g = 0; g < 3; g++) begin
      chk("rst.vld", 64'(ovld[g]), 64'd0);
      chk("rst.imm", oimm[g], 64'd0);
      chk("rst.instr", 64'(oinstr[g]), 64'd0);
      chk("rst.fmt", 64'(ofmt[g]), 64'd0);
      chk("rst.ill", 64'(oill[g]), 64'd0);
      chk("rst.rdy", 64'(irdy[g]), 64'd1);
    end
    rst_n = 1'b1;
    step();

    // directed vectors, back-to-back with out_ready high
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = 32'hFFF00093; step();
    chk("addi.imm", oimm[0], 64'hFFFF_FFFF);
    chk("addi.fmt", 64'(ofmt[0]), 64'd1);
    chk("addi.ill", 64'(oill[0]), 64'd0);
    in_instr = 32'h004000EF; step();
    chk("jal.imm", oimm[0], 64'h4);
    chk("jal.fmt", 64'(ofmt[0]), 64'd5);
    in_instr = 32'hFE000EE3; step();
    chk("beq.vld", 64'(ovld[0]), 64'd1);
    chk("beq.imm", oimm[0], 64'hFFFF_FFFC);
    chk("beq.fmt", 64'(ofmt[0]), 64'd3);
    in_instr = 32'h800000B7; step();
    chk("lui64.imm", oimm[1], 64'hFFFF_FFFF_8000_0000);
    chk("lui64.fmt", 64'(ofmt[1]), 64'd4);
    in_instr = 32'h03F09093; step();
    in_valid = 1'b0;
    chk("slli64.imm", oimm[1], 64'd63);
    chk("slli64.ill", 64'(oill[1]), 64'd0);
    chk("slli32.ill", 64'(oill[0]), 64'd1);
    step();
    chk("idle.vld", 64'(ovld[0]), 64'd0);

    // backpressure: two land, third waits, then FIFO drain
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100113; step();
    in_instr = 32'h00200193; step();
    chk("skid.full.rdy", 64'(irdy[0]), 64'd0);
    in_instr = 32'h00300213; step();
    step();
    chk("skid.stall.instr", 64'(oinstr[0]), 64'h00100113);
    chk("skid.stall.rdy", 64'(irdy[0]), 64'd0);
    out_ready = 1'b1; step();
    chk("skid.b.instr", 64'(oinstr[0]), 64'h00200193);
    chk("skid.b.rdy", 64'(irdy[0]), 64'd1);
    step();
    in_valid = 1'b0;
    chk("skid.c.instr", 64'(oinstr[0]), 64'h00300213);
    step();
    chk("skid.empty", 64'(ovld[0]), 64'd0);

    // flush with two held and an input offered the same cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00A00513; step();
    in_instr = 32'h00B00593; step();
    flush = 1'b1; in_instr = 32'h00C00613; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.vld", 64'(ovld[0]), 64'd0);
    chk("flush.rdy", 64'(irdy[0]), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // flush from empty with in_ready high still discards the offer
    in_valid = 1'b1; flush = 1'b1; in_instr = 32'h00D00693; step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.empty.vld", 64'(ovld[0]), 64'd0);

    rand_run(600);

    // asynchronous reset pulse between edges while holding data
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093;
    step(); step();
    in_valid = 1'b0;
    chk("prerst.vld", 64'(ovld[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("arst.vld", 64'(ovld[g]), 64'd0);
      chk("arst.imm", oimm[g], 64'd0);
    end
    rst_n = 1'b1;
    step();

    rand_run(300);
    out_ready = 1'b1;
    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
